// File: rtl/seg_digit_driver.sv
// seg_digit_driver
//   Segment-data side of a 3-digit multiplexed 7-segment display. A binary
//   reading (0..999) is accepted through a load/busy handshake and converted
//   to BCD by an iterative double-dabble FSM. The result is held in a shadow
//   register and committed to the displayed digits only at a frame start
//   (dig_sel == 3'b011), so a frame never mixes old and new digits.
//
// Ports
//   clk      system clock
//   rst      asynchronous active-high reset
//   dig_sel  active-low digit select from the scan ring (bit2 hundreds,
//            bit1 tens, bit0 ones)
//   value    binary reading, sampled when a load is accepted
//   load     conversion request, accepted only while busy = 0
//   busy     conversion in progress (11 clocks after the accept edge)
//   ovf      committed reading was > 999 (all digits show a dash)
//   seg      registered segment bus {dp,g,f,e,d,c,b,a}
//
// Parameters
//   SEG_ACTIVE_LOW  1 inverts every seg output (common-anode panel)
//   LZB             1 enables leading-zero blanking on hundreds and tens

module seg_digit_driver #(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit LZB            = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] dig_sel,
  input  logic [9:0] value,
  input  logic       load,
  output logic       busy,
  output logic       ovf,
  output logic [7:0] seg
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [9:0]  r_bin;
  logic [11:0] r_bcd;
  logic [3:0]  r_cnt;
  logic        r_ovf_scr;

  logic [11:0] r_sh_bcd;
  logic        r_sh_ovf;
  logic        r_pending;

  logic [11:0] r_cm_bcd;
  logic        r_cm_ovf;

  logic [7:0]  r_seg;

  logic [11:0] w_bcd_adj;
  logic [21:0] w_shift;
  logic        w_commit;
  logic [11:0] w_disp_bcd;
  logic        w_disp_ovf;
  logic [3:0]  w_hund;
  logic [3:0]  w_tens;
  logic [3:0]  w_ones;
  logic [7:0]  w_seg_raw;
  logic [7:0]  w_seg_nxt;

  function automatic logic [7:0] dec7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (load) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == 4'd9) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5)
        w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
    w_shift = {w_bcd_adj, r_bin} << 1;
  end

  // ---------------------------------------------------------------------------
  // Commit and segment selection
  // ---------------------------------------------------------------------------
  assign w_commit = (dig_sel == 3'b011) && r_pending;

  // On a commit edge the freshly committed digits feed the seg register
  // directly, so the hundreds digit shown at frame start is already new.
  assign w_disp_bcd = w_commit ? r_sh_bcd : r_cm_bcd;
  assign w_disp_ovf = w_commit ? r_sh_ovf : r_cm_ovf;
  assign w_hund     = w_disp_bcd[11:8];
  assign w_tens     = w_disp_bcd[7:4];
  assign w_ones     = w_disp_bcd[3:0];

  always_comb begin
    w_seg_raw = SEG_BLANK;
    case (dig_sel)
      3'b011: begin
        if (w_disp_ovf)                 w_seg_raw = SEG_DASH;
        else if (LZB && w_hund == 4'd0) w_seg_raw = SEG_BLANK;
        else                            w_seg_raw = dec7(w_hund);
      end
      3'b101: begin
        if (w_disp_ovf)                                     w_seg_raw = SEG_DASH;
        else if (LZB && w_hund == 4'd0 && w_tens == 4'd0)   w_seg_raw = SEG_BLANK;
        else                                                w_seg_raw = dec7(w_tens);
      end
      3'b110: begin
        if (w_disp_ovf) w_seg_raw = SEG_DASH;
        else            w_seg_raw = dec7(w_ones);
      end
      default: w_seg_raw = SEG_BLANK;
    endcase
    w_seg_nxt = SEG_ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_ovf_scr <= 1'b0;
      r_sh_bcd  <= '0;
      r_sh_ovf  <= 1'b0;
      r_pending <= 1'b0;
      r_cm_bcd  <= '0;
      r_cm_ovf  <= 1'b0;
      r_seg     <= {8{SEG_ACTIVE_LOW}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_bin     <= value;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf_scr <= (value > 10'd999);
          end
        end
        S_SHIFT: begin
          r_bcd <= w_shift[21:10];
          r_bin <= w_shift[9:0];
          r_cnt <= r_cnt + 4'd1;
        end
        S_DONE: begin
          r_sh_bcd <= r_bcd;
          r_sh_ovf <= r_ovf_scr;
        end
        default: ;
      endcase

      // A DONE coinciding with frame start commits the previous shadow;
      // the new result stays pending for the next frame start.
      if (r_state == S_DONE) r_pending <= 1'b1;
      else if (w_commit)     r_pending <= 1'b0;

      if (w_commit) begin
        r_cm_bcd <= r_sh_bcd;
        r_cm_ovf <= r_sh_ovf;
      end

      r_seg <= w_seg_nxt;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign ovf  = r_cm_ovf;
  assign seg  = r_seg;

endmodule

// File: tb/tb_seg_digit_driver.sv
// Directed bench for seg_digit_driver. Three instances share the stimulus:
// default build (LZB=1), LZB=0, and SEG_ACTIVE_LOW=1. Expected seg bytes are
// computed from a decimal model of the committed reading and pushed to a
// queue when dig_sel is driven, then popped when the registered seg appears.

module tb_seg_digit_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dig_sel;
  logic [9:0] value;
  logic       load;

  logic       busy0, busy1, busy2;
  logic       ovf0, ovf1, ovf2;
  logic [7:0] seg0, seg1, seg2;

  int total = 0;
  int bad   = 0;

  // committed display model and shadow model
  int m_h, m_t, m_o;
  bit m_ovf;
  int s_h, s_t, s_o;
  bit s_ovf;
  bit m_pend;

  typedef struct {
    logic [2:0] ds;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } exp_t;

  exp_t sbq[$];

  localparam logic [7:0] SEG_TAB [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                           8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  seg_digit_driver #(.SEG_ACTIVE_LOW(1'b0), .LZB(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .dig_sel(dig_sel), .value(value), .load(load),
    .busy(busy0), .ovf(ovf0), .seg(seg0)
  );

  seg_digit_driver #(.SEG_ACTIVE_LOW(1'b0), .LZB(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .dig_sel(dig_sel), .value(value), .load(load),
    .busy(busy1), .ovf(ovf1), .seg(seg1)
  );

  seg_digit_driver #(.SEG_ACTIVE_LOW(1'b1), .LZB(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .dig_sel(dig_sel), .value(value), .load(load),
    .busy(busy2), .ovf(ovf2), .seg(seg2)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] exp_seg(input logic [2:0] ds, input bit lzb, input bit sal);
    logic [7:0] r;
    r = 8'h00;
    if (ds == 3'b011)
      r = m_ovf ? 8'h40 : ((lzb && m_h == 0) ? 8'h00 : SEG_TAB[m_h]);
    else if (ds == 3'b101)
      r = m_ovf ? 8'h40 : ((lzb && m_h == 0 && m_t == 0) ? 8'h00 : SEG_TAB[m_t]);
    else if (ds == 3'b110)
      r = m_ovf ? 8'h40 : SEG_TAB[m_o];
    return sal ? ~r : r;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_ring(input logic [2:0] ds);
    exp_t e;
    dig_sel = ds;
    if (ds == 3'b011 && m_pend) begin
      m_h = s_h; m_t = s_t; m_o = s_o; m_ovf = s_ovf;
      m_pend = 1'b0;
    end
    e.ds = ds;
    e.e0 = exp_seg(ds, 1'b1, 1'b0);
    e.e1 = exp_seg(ds, 1'b0, 1'b0);
    e.e2 = exp_seg(ds, 1'b1, 1'b1);
    sbq.push_back(e);
    tick();
    e = sbq.pop_front();
    check($sformatf("seg_lzb1 ds=%b", e.ds), seg0, e.e0);
    check($sformatf("seg_lzb0 ds=%b", e.ds), seg1, e.e1);
    check($sformatf("seg_al ds=%b", e.ds), seg2, e.e2);
  endtask

  task automatic frame();
    step_ring(3'b011);
    step_ring(3'b110);
    step_ring(3'b101);
  endtask

  // Issue a load and measure busy; optionally retry a load at busy cycle inj.
  task automatic do_load(input int v, input int inj);
    int n;
    dig_sel = 3'b111;
    value   = v[9:0];
    load    = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy0 === 1'b1 && n < 30) begin
      n++;
      if (n == inj) begin
        value = 10'd300;
        load  = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    check($sformatf("busy_len v=%0d", v), 8'(n), 8'd11);
    s_h   = (v / 100) % 10;
    s_t   = (v / 10) % 10;
    s_o   = v % 10;
    s_ovf = (v > 999);
    m_pend = 1'b1;
  endtask

  task automatic model_reset();
    m_h = 0; m_t = 0; m_o = 0; m_ovf = 1'b0;
    s_h = 0; s_t = 0; s_o = 0; s_ovf = 1'b0;
    m_pend = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    value   = '0;
    dig_sel = 3'b111;
    model_reset();

    // reset state
    tick();
    check("rst_busy0", 8'(busy0), 8'd0);
    check("rst_busy1", 8'(busy1), 8'd0);
    check("rst_busy2", 8'(busy2), 8'd0);
    check("rst_ovf0", 8'(ovf0), 8'd0);
    check("rst_seg0", seg0, 8'h00);
    check("rst_seg2", seg2, 8'hFF);
    tick();
    rst = 1'b0;

    // free-running ring with no load shows "  0"
    frame();
    frame();
    check("idle_busy", 8'(busy0), 8'd0);

    // 123
    do_load(123, -1);
    frame();
    frame();

    // 7: leading-zero blanking on the LZB=1 build, zeros on LZB=0
    do_load(7, -1);
    frame();

    // overflow, then back to a valid reading
    do_load(1000, -1);
    frame();
    check("ovf_set0", 8'(ovf0), 8'd1);
    check("ovf_set2", 8'(ovf2), 8'd1);
    do_load(999, -1);
    frame();
    check("ovf_clr0", 8'(ovf0), 8'd0);
    check("ovf_clr1", 8'(ovf1), 8'd0);

    // load while busy is ignored
    do_load(45, 3);
    frame();

    // two conversions before a frame start: the later one wins
    do_load(11, -1);
    do_load(22, -1);
    frame();

    // asynchronous reset in the middle of a conversion of 888
    do_load(45, -1);
    frame();
    step_ring(3'b110);
    value = 10'd888;
    load  = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 8'(busy0), 8'd0);
    check("arst_seg0", seg0, 8'h00);
    check("arst_seg1", seg1, 8'h00);
    check("arst_seg2", seg2, 8'hFF);
    model_reset();
    value = 10'd5;
    load  = 1'b1;
    tick();
    load = 1'b0;
    rst  = 1'b0;
    check("post_rst_busy", 8'(busy0), 8'd0);
    repeat (14) tick();
    check("post_rst_idle", 8'(busy0), 8'd0);
    frame();
    frame();

    // invalid digit selects blank the segment bus
    do_load(52, -1);
    frame();
    step_ring(3'b111);
    step_ring(3'b001);
    step_ring(3'b000);
    step_ring(3'b010);
    frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
